// File: rtl/rv_mem_arb.sv
// rtl/rv_mem_arb.sv - fetch/data arbiter and fixed-latency sequencer for one shared single-port memory
// Optional macro ARB_RR_EN: round-robin arbitration instead of fixed data-over-fetch priority.

module rv_mem_arb #(
    parameter int DPWIDTH = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [DPWIDTH-1:0] if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [DPWIDTH-1:0] if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [DPWIDTH-1:0] d_addr,
    input  logic [DPWIDTH-1:0] d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [DPWIDTH-1:0] d_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [DPWIDTH-1:0] mem_addr,
    output logic [DPWIDTH-1:0] mem_wdata,
    input  logic [DPWIDTH-1:0] mem_rdata,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t             state_q;
    logic               owner_data_q;
    logic               we_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic               if_rvalid_q;
    logic               d_rvalid_q;
    logic               busy_q;
    logic [3:0]         cnt_q;
    logic [DPWIDTH-1:0] addr_q;
    logic [DPWIDTH-1:0] wdata_q;
    logic [DPWIDTH-1:0] if_rdata_q;
    logic [DPWIDTH-1:0] d_rdata_q;

    logic               grant;
    logic               sel_data;

`ifdef ARB_RR_EN
    logic last_fetch_q;

    // On a tie the requester that was not served last wins.
    assign sel_data = d_req && (!if_req || last_fetch_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_fetch_q <= 1'b1;
        end else if (grant) begin
            last_fetch_q <= !sel_data;
        end
    end
`else
    assign sel_data = d_req;
`endif

    // Grants are combinational so the requester sees acceptance in its request cycle.
    assign grant  = (state_q == S_IDLE) && (if_req || d_req) && !rst;
    assign d_gnt  = grant && sel_data;
    assign if_gnt = grant && !sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        owner_data_q <= sel_data;
                        we_q         <= sel_data && d_we;
                        addr_q       <= sel_data ? d_addr : if_addr;
                        if (sel_data) begin
                            wdata_q <= d_wdata;
                        end
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= sel_data && d_we;
                        busy_q       <= 1'b1;
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt_q    <= CNT_LOAD;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // Count 0 marks the cycle the memory presents its read data.
                    if (cnt_q == 4'd0) begin
                        if (owner_data_q) begin
                            d_rdata_q  <= we_q ? '0 : mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb/tb_rv_mem_arb.sv - self-checking bench for rv_mem_arb with memory models at MEM_LAT=2 and MEM_LAT=1

module tb_rv_mem_arb;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_req_1, if_gnt_1, if_rvalid_1, d_req_1, d_we_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1, busy_1;
    logic [31:0] if_addr_1, if_rdata_1, d_addr_1, d_wdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

    int n_pass = 0;
    int n_total = 0;

    rv_mem_arb #(.DPWIDTH(32), .MEM_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    rv_mem_arb #(.DPWIDTH(32), .MEM_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1)
    );

    // Fixed-latency memories: read data is presented only in the cycle MEM_LAT after mem_en, noise otherwise.
    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];
    int          rd_cnt0 = 0;
    int          rd_cnt1 = 0;
    logic [31:0] rd_dat0, rd_dat1;

    always @(negedge clk) begin
        mem_rdata <= (rd_cnt0 == 1) ? rd_dat0 : $urandom;
        if (mem_en && !mem_we) begin
            rd_cnt0 <= LAT0;
            rd_dat0 <= mem0[mem_addr[9:2]];
        end else if (rd_cnt0 != 0) begin
            rd_cnt0 <= rd_cnt0 - 1;
        end
        if (mem_en && mem_we) mem0[mem_addr[9:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        mem_rdata_1 <= (rd_cnt1 == 1) ? rd_dat1 : $urandom;
        if (mem_en_1 && !mem_we_1) begin
            rd_cnt1 <= LAT1;
            rd_dat1 <= mem1[mem_addr_1[9:2]];
        end else if (rd_cnt1 != 0) begin
            rd_cnt1 <= rd_cnt1 - 1;
        end
        if (mem_en_1 && mem_we_1) mem1[mem_addr_1[9:2]] <= mem_wdata_1;
    end

    task automatic idle_inputs();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_req_1 = 1'b0; d_req_1 = 1'b0; d_we_1 = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0) $display("FAIL por_ctrl: got %b want 0", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}); else n_pass++;
        n_total++; if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) $display("FAIL por_data: got %h want 0", {if_rdata, d_rdata, mem_addr, mem_wdata}); else n_pass++;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if_req = (c == 0) || (c == 6);
            if_addr = 32'h40;
            rst = (c == 2) || (c == 3);
            #3;
            n_total++; if (if_gnt !== (c inside {0, 6})) $display("FAIL rst_if_gnt c=%0d: got %b want %b", c, if_gnt, c inside {0, 6}); else n_pass++;
            n_total++; if (mem_en !== (c inside {1, 7})) $display("FAIL rst_mem_en c=%0d: got %b want %b", c, mem_en, c inside {1, 7}); else n_pass++;
            n_total++; if (busy !== (c inside {1, 2, 7, 8, 9, 10})) $display("FAIL rst_busy c=%0d: got %b", c, busy); else n_pass++;
            n_total++; if (if_rvalid !== (c == 10)) $display("FAIL rst_if_rvalid c=%0d: got %b want %b", c, if_rvalid, c == 10); else n_pass++;
            if (c == 3 || c == 4) begin
                n_total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0) $display("FAIL rst_ctrl c=%0d: got %b want 0", c, {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}); else n_pass++;
                n_total++; if ({if_rdata, d_rdata, mem_addr} !== 96'b0) $display("FAIL rst_data c=%0d: got %h want 0", c, {if_rdata, d_rdata, mem_addr}); else n_pass++;
            end
            if (c == 10) begin
                n_total++; if (if_rdata !== mem0[16]) $display("FAIL rst_reissue_rdata: got %h want %h", if_rdata, mem0[16]); else n_pass++;
            end
        end
    endtask

    task automatic test_data_write();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            d_req = (c == 0); d_we = (c == 0); d_addr = 32'h200; d_wdata = 32'h12345678;
            #3;
            n_total++; if (d_gnt !== (c == 0)) $display("FAIL wr_d_gnt c=%0d: got %b want %b", c, d_gnt, c == 0); else n_pass++;
            n_total++; if ({mem_en, mem_we} !== {c == 1, c == 1}) $display("FAIL wr_mem_strobe c=%0d: got %b", c, {mem_en, mem_we}); else n_pass++;
            if (c == 1) begin
                n_total++; if ({mem_addr, mem_wdata} !== {32'h200, 32'h12345678}) $display("FAIL wr_mem_bus: got %h want 0000020012345678", {mem_addr, mem_wdata}); else n_pass++;
            end
            n_total++; if (d_rvalid !== (c == 4)) $display("FAIL wr_d_rvalid c=%0d: got %b want %b", c, d_rvalid, c == 4); else n_pass++;
            n_total++; if (if_rvalid !== 1'b0) $display("FAIL wr_if_rvalid c=%0d: got %b want 0", c, if_rvalid); else n_pass++;
            n_total++; if (busy !== (c inside {[1:4]})) $display("FAIL wr_busy c=%0d: got %b", c, busy); else n_pass++;
            if (c == 4) begin
                n_total++; if (d_rdata !== 32'h0) $display("FAIL wr_d_rdata: got %h want 0", d_rdata); else n_pass++;
            end
        end
        n_total++; if (mem0[128] !== 32'h12345678) $display("FAIL wr_mem_content: got %h want 12345678", mem0[128]); else n_pass++;
    endtask

    task automatic test_fetch_read();
        for (int p = 0; p < 5; p++) begin
            @(posedge clk); #1;
            d_req = (p == 0); d_we = (p == 0); d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        end
        d_we = 1'b0;
        n_total++; if (mem0[64] !== 32'hDEADBEEF) $display("FAIL rd_preload: got %h want deadbeef", mem0[64]); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if_req = (c == 0); if_addr = 32'h100;
            #3;
            n_total++; if (if_gnt !== (c == 0)) $display("FAIL rd_if_gnt c=%0d: got %b want %b", c, if_gnt, c == 0); else n_pass++;
            n_total++; if ({mem_en, mem_we} !== {c == 1, 1'b0}) $display("FAIL rd_mem_strobe c=%0d: got %b", c, {mem_en, mem_we}); else n_pass++;
            if (c == 1) begin
                n_total++; if (mem_addr !== 32'h100) $display("FAIL rd_mem_addr: got %h want 100", mem_addr); else n_pass++;
            end
            n_total++; if (busy !== (c inside {[1:4]})) $display("FAIL rd_busy c=%0d: got %b", c, busy); else n_pass++;
            n_total++; if ({if_rvalid, d_rvalid} !== {c == 4, 1'b0}) $display("FAIL rd_rvalid c=%0d: got %b", c, {if_rvalid, d_rvalid}); else n_pass++;
            if (c >= 4) begin
                n_total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL rd_if_rdata c=%0d: got %h want deadbeef", c, if_rdata); else n_pass++;
            end
        end
    endtask

    // Tie at 0 after reset, data-only round at 10, tie again at 15.
    task automatic test_contention();
        bit dg [0:25];
        bit ig [0:25];
        bit dp, ip, edv, eiv;
        for (int c = 0; c < 26; c++) begin
            dg[c] = (c == 0) || (c == 10) || (c == 15 && !RR) || (c == 20 && RR);
            ig[c] = (c == 5) || (c == 15 && RR) || (c == 20 && !RR);
        end
        do_reset(2);
        dp = 1'b0; ip = 1'b0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            if (c == 0 || c == 15) begin dp = 1'b1; ip = 1'b1; end
            if (c == 10) dp = 1'b1;
            d_req = dp; d_we = 1'b0; d_addr = 32'h200; if_req = ip; if_addr = 32'h100;
            #3;
            edv = (c >= 4) ? dg[c - 4] : 1'b0;
            eiv = (c >= 4) ? ig[c - 4] : 1'b0;
            n_total++; if ({d_gnt, if_gnt} !== {dg[c], ig[c]}) $display("FAIL arb_gnt c=%0d: got %b want %b", c, {d_gnt, if_gnt}, {dg[c], ig[c]}); else n_pass++;
            n_total++; if ({d_rvalid, if_rvalid} !== {edv, eiv}) $display("FAIL arb_rvalid c=%0d: got %b want %b", c, {d_rvalid, if_rvalid}, {edv, eiv}); else n_pass++;
            if (edv) begin
                n_total++; if (d_rdata !== mem0[128]) $display("FAIL arb_d_rdata c=%0d: got %h want %h", c, d_rdata, mem0[128]); else n_pass++;
            end
            if (eiv) begin
                n_total++; if (if_rdata !== mem0[64]) $display("FAIL arb_if_rdata c=%0d: got %h want %h", c, if_rdata, mem0[64]); else n_pass++;
            end
            if (dg[c]) dp = 1'b0;
            if (ig[c]) ip = 1'b0;
        end
    endtask

    // Reference model: one transaction occupies the memory for MEM_LAT+3 cycles from its grant.
    task automatic test_random(input int n);
        int          free_at, t_gnt;
        bit          have, t_data, t_we, last_fetch, g_i_prev, g_d_prev, eig, edg, emen, eiv, edv;
        logic [31:0] t_addr, t_wdata, t_rd, exp_ird, exp_drd;
        do_reset(2);
        free_at = 0; t_gnt = 0; have = 1'b0; t_data = 1'b0; t_we = 1'b0; last_fetch = 1'b1;
        g_i_prev = 1'b0; g_d_prev = 1'b0; exp_ird = 32'h0; exp_drd = 32'h0;
        t_addr = 32'h0; t_wdata = 32'h0; t_rd = 32'h0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (g_i_prev || !if_req) begin
                if_req = ($urandom_range(0, 2) == 0);
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (g_d_prev || !d_req) begin
                d_req = ($urandom_range(0, 2) == 0);
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            #3;
            eig = 1'b0; edg = 1'b0;
            if (c >= free_at && (if_req || d_req)) begin
                t_data = RR ? (d_req && (!if_req || last_fetch)) : d_req;
                eig = !t_data; edg = t_data; last_fetch = !t_data;
                have = 1'b1; t_gnt = c; free_at = c + LAT0 + 3;
                t_we = t_data && d_we;
                t_addr = t_data ? d_addr : if_addr;
                t_wdata = d_wdata;
                t_rd = t_we ? 32'h0 : mem0[t_addr[9:2]];
            end
            emen = have && (c == t_gnt + 1);
            eiv = have && (c == t_gnt + LAT0 + 2) && !t_data;
            edv = have && (c == t_gnt + LAT0 + 2) && t_data;
            if (eiv) exp_ird = t_rd;
            if (edv) exp_drd = t_rd;
            n_total++; if ({if_gnt, d_gnt} !== {eig, edg}) $display("FAIL rnd_gnt c=%0d: got %b want %b", c, {if_gnt, d_gnt}, {eig, edg}); else n_pass++;
            n_total++; if ({mem_en, mem_we} !== {emen, emen && t_we}) $display("FAIL rnd_strobe c=%0d: got %b want %b", c, {mem_en, mem_we}, {emen, emen && t_we}); else n_pass++;
            n_total++; if (busy !== (have && c > t_gnt && c < free_at)) $display("FAIL rnd_busy c=%0d: got %b", c, busy); else n_pass++;
            n_total++; if ({if_rvalid, d_rvalid} !== {eiv, edv}) $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, {if_rvalid, d_rvalid}, {eiv, edv}); else n_pass++;
            n_total++; if ({if_rdata, d_rdata} !== {exp_ird, exp_drd}) $display("FAIL rnd_rdata c=%0d: got %h want %h", c, {if_rdata, d_rdata}, {exp_ird, exp_drd}); else n_pass++;
            if (emen) begin
                n_total++; if (mem_addr !== t_addr) $display("FAIL rnd_mem_addr c=%0d: got %h want %h", c, mem_addr, t_addr); else n_pass++;
            end
            if (emen && t_we) begin
                n_total++; if (mem_wdata !== t_wdata) $display("FAIL rnd_mem_wdata c=%0d: got %h want %h", c, mem_wdata, t_wdata); else n_pass++;
            end
            g_i_prev = eig; g_d_prev = edg;
        end
        idle_inputs();
    endtask

    task automatic test_lat1();
        logic [31:0] wval, exp_ird;
        wval = $urandom | 32'h1;
        for (int c = 0; c < 17; c++) begin
            @(posedge clk); #1;
            d_req_1 = (c == 0); d_we_1 = (c == 0); d_addr_1 = 32'h80; d_wdata_1 = wval;
            if_req_1 = (c inside {4, 8, 12}); if_addr_1 = 32'h80;
            rst = (c == 10);
            #3;
            exp_ird = ((c >= 7 && c <= 10) || c >= 15) ? wval : 32'h0;
            n_total++; if ({d_gnt_1, if_gnt_1} !== {c == 0, c inside {4, 8, 12}}) $display("FAIL l1_gnt c=%0d: got %b", c, {d_gnt_1, if_gnt_1}); else n_pass++;
            n_total++; if ({mem_en_1, mem_we_1} !== {c inside {1, 5, 9, 13}, c == 1}) $display("FAIL l1_strobe c=%0d: got %b", c, {mem_en_1, mem_we_1}); else n_pass++;
            n_total++; if ({d_rvalid_1, if_rvalid_1} !== {c == 3, c inside {7, 15}}) $display("FAIL l1_rvalid c=%0d: got %b", c, {d_rvalid_1, if_rvalid_1}); else n_pass++;
            n_total++; if (busy_1 !== (c inside {1, 2, 3, 5, 6, 7, 9, 10, 13, 14, 15})) $display("FAIL l1_busy c=%0d: got %b", c, busy_1); else n_pass++;
            n_total++; if (if_rdata_1 !== exp_ird) $display("FAIL l1_if_rdata c=%0d: got %h want %h", c, if_rdata_1, exp_ird); else n_pass++;
            n_total++; if (d_rdata_1 !== 32'h0) $display("FAIL l1_d_rdata c=%0d: got %h want 0", c, d_rdata_1); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        if_addr_1 = 32'h0; d_addr_1 = 32'h0; d_wdata_1 = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_data_write();
        test_fetch_read();
        test_contention();
        test_random(400);
        test_lat1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Arbiter and sequencer sharing one single-port, fixed-latency memory between the multicycle core's instruction-fetch requester and its data-access requester.
- Sits between the rv_* datapath/control memory interface and a unified instruction/data memory.
- Grants one requester at a time and drives the memory strobe.
- Times the memory read latency and returns a registered response with a one-cycle valid pulse.

Parameters:
- DPWIDTH, 32, address and data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  DPWIDTH  fetch address; stable while if_req=1.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle fetch response pulse.
- if_rdata  out  DPWIDTH  fetch data; valid with if_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1=write, 0=read.
- d_addr  in  DPWIDTH  data address.
- d_wdata  in  DPWIDTH  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle data response/write-ack pulse.
- d_rdata  out  DPWIDTH  read data; 0 on write ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  DPWIDTH  memory address.
- mem_wdata  out  DPWIDTH  memory write data.
- mem_rdata  in  DPWIDTH  memory read data.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Owner is none.
  - Round-robin pointer (if present) is "fetch last".
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a winner (arbitration below).
  - Pulse the winner's gnt combinationally in the same cycle.
  - Latch the winner's addr, we, wdata and owner. A fetch always latches we=0.
  - Go to ACCESS.
  - With no req, stay in IDLE and keep both gnt outputs at 0.
- ACCESS (1 cycle):
  - mem_en=1, mem_we=latched we.
  - mem_addr and mem_wdata are driven from the latches.
  - Load the counter with MEM_LAT-1, then go to WAIT.
- WAIT:
  - Hold mem_en=0 and mem_we=0.
  - Decrement the counter each cycle.
  - In the cycle the counter reads 0, register mem_rdata into the owner's rdata (0 for a write) and go to RESP.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- RESP (1 cycle):
  - Owner's rvalid=1 for this cycle; the other requester's rvalid=0.
  - No grant is issued in RESP.
  - Next state is IDLE.
- Latency: gnt in cycle T; mem_en in T+1; rvalid in T+2+MEM_LAT. Throughput is one transaction per MEM_LAT+3 cycles.
- mem_we is only ever 1 while mem_en=1.
- mem_addr and mem_wdata hold their last value between accesses.
- rdata outputs hold their value until the next response to the same requester.
- Base arbitration: fixed priority, data over fetch. The fetch requester may starve under continuous d_req.
- A req that drops before its gnt is ignored; no transaction is issued for it.
- gnt never asserts outside IDLE.
- Reset mid-operation:
  - The transaction is aborted and no rvalid is issued.
  - The requester must reissue the request.
  - mem_en=0 from the cycle after rst is sampled.

Optional Feature:
- Macro: ARB_RR_EN.
- When defined: round-robin arbitration.
  - A 1-bit last-owner register is updated on every gnt.
  - When both requesters are high in IDLE, grant the one not granted last.
  - A single requester is always granted.
- When undefined: fixed data-over-fetch priority as above, and the last-owner register is not implemented.

Test Plan:
- Reset: assert rst 2 cycles mid-sequence -> all outputs 0, busy=0, state IDLE next cycle.
- Fetch read, MEM_LAT=2: if_req with if_addr=0x100 at cycle 0; memory returns 0xDEADBEEF in cycle 3 -> if_gnt@0, mem_en=1/mem_we=0/mem_addr=0x100 @1, if_rvalid=1 with if_rdata=0xDEADBEEF @4, busy 1..4.
- Data write: d_req with d_we=1, d_addr=0x200, d_wdata=0x12345678 at cycle 0 -> d_gnt@0, mem_en=mem_we=1 with mem_wdata=0x12345678 @1, d_rvalid=1 with d_rdata=0 @4, if_rvalid stays 0.
- Contention, fixed priority: if_req and d_req both high from cycle 0 -> d_gnt@0, d_rvalid@4, if_gnt@5, if_rvalid@9.
- Contention with ARB_RR_EN: both held high across two rounds after a fetch-last reset -> d_gnt@0 then if_gnt@5; after a subsequent data-owned round, fetch is granted first on the next tie.
- Boundary MEM_LAT=1 plus reset mid-op: normal read gives mem_en@1, rvalid@3; rst asserted at cycle 2 of a second transaction -> no rvalid, mem_en=0, re-request granted normally.
